// File: rtl/stack_calc_core.sv
// -----------------------------------------------------------------------------
// stack_calc_core
//   Stack-calculator engine. Owns the stack RAM (synchronous read), the entry
//   count and the display address register. Executes one command per
//   cmd_valid/cmd_ready handshake and answers with a one-cycle rsp_valid strobe.
//
//   The stack grows downward: entry i (0 = bottom) lives at address DEPTH-1-i,
//   so the top of a non-empty stack is at DEPTH-count and the next push goes
//   to DEPTH-1-count (both modulo DEPTH).
//
// Parameters
//   DW  data width of stack entries and operands
//   AW  address width, DEPTH = 2**AW
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command request, held until accepted
//   cmd_ready  high only while idle
//   cmd_op     0 PUSH,1 POP,2 ADD,3 SUB,4 TOP,5 CLEAR,6 PEEK_INC,7 PEEK_DEC
//   cmd_din    PUSH operand
//   rsp_valid  one-cycle response strobe
//   rsp_data   result value
//   rsp_err    00 ok, 01 underflow, 10 overflow
//   rsp_cy     ADD carry-out / SUB borrow, 0 otherwise
//   count      number of entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   dar        display address register
// -----------------------------------------------------------------------------
module stack_calc_core #(
  parameter int DW = 8,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_din,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [1:0]    rsp_err,
  output logic          rsp_cy,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] dar
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [2:0] OP_PUSH     = 3'd0;
  localparam logic [2:0] OP_POP      = 3'd1;
  localparam logic [2:0] OP_ADD      = 3'd2;
  localparam logic [2:0] OP_SUB      = 3'd3;
  localparam logic [2:0] OP_TOP      = 3'd4;
  localparam logic [2:0] OP_CLEAR    = 3'd5;
  localparam logic [2:0] OP_PEEK_INC = 3'd6;
  localparam logic [2:0] OP_PEEK_DEC = 3'd7;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;

  localparam logic [AW-1:0] A_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   C_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   C_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   C_TWO   = {{(AW-1){1'b0}}, 2'b10};
  localparam logic [AW:0]   C_DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [DW-1:0] D_ZERO  = {DW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t          state_r;
  logic [2:0]      op_r;
  logic [AW:0]     count_r;
  logic            empty_r;
  logic            full_r;
  logic [AW-1:0]   dar_r;
  logic            cmd_ready_r;
  logic            rsp_valid_r;
  logic [DW-1:0]   rsp_data_r;
  logic [1:0]      rsp_err_r;
  logic            rsp_cy_r;
  logic [DW-1:0]   a_r;
  logic [AW-1:0]   wr_addr_r;
  logic [DW-1:0]   wr_data_r;
  logic            cy_r;

  logic [DW-1:0]   mem_r [DEPTH];
  logic [DW-1:0]   rd_data_r;

  logic [AW:0]     top_full_s;
  logic [AW-1:0]   top_addr_s;
  logic [AW-1:0]   push_addr_s;
  logic [AW-1:0]   dar_inc_s;
  logic [AW-1:0]   dar_dec_s;
  logic [AW-1:0]   rd_addr_s;
  logic            wr_en_s;
  logic [DW:0]     sum_s;
  logic [DW:0]     diff_s;

  // Address arithmetic derived from the current count and dar.
  always_comb begin
    top_full_s  = C_DEPTH - count_r;
    top_addr_s  = top_full_s[AW-1:0];
    push_addr_s = top_addr_s - A_ONE;
    dar_inc_s   = dar_r + A_ONE;
    dar_dec_s   = dar_r - A_ONE;
  end

  // Read address: top (or peek target) on the accept edge, the second operand
  // (one slot below the top in stack order, i.e. top+1) while in RD_A.
  always_comb begin
    rd_addr_s = top_addr_s;
    if (state_r == S_IDLE) begin
      case (cmd_op)
        OP_PEEK_INC: rd_addr_s = dar_inc_s;
        OP_PEEK_DEC: rd_addr_s = dar_dec_s;
        default:     rd_addr_s = top_addr_s;
      endcase
    end else if (state_r == S_RD_A) begin
      rd_addr_s = top_addr_s + A_ONE;
    end else begin
      rd_addr_s = top_addr_s;
    end
  end

  // Write strobe comes straight from the state register so an async reset
  // taken in WR suppresses the pending write.
  always_comb begin
    wr_en_s = (state_r == S_WR) && (op_r != OP_PUSH || !full_r);
  end

  // ALU for ADD/SUB: b is the RAM word arriving in RD_B, a was captured in RD_A.
  // The extra top bit is the carry for ADD and the borrow (b < a) for SUB.
  always_comb begin
    sum_s  = {1'b0, rd_data_r} + {1'b0, a_r};
    diff_s = {1'b0, rd_data_r} - {1'b0, a_r};
  end

  // Stack storage: synchronous-read, single-write RAM without reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_r] <= wr_data_r;
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Command FSM with registered handshake, response and stack-state outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      op_r        <= OP_PUSH;
      count_r     <= C_ZERO;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      dar_r       <= A_ZERO;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= D_ZERO;
      rsp_err_r   <= ERR_OK;
      rsp_cy_r    <= 1'b0;
      a_r         <= D_ZERO;
      wr_addr_r   <= A_ZERO;
      wr_data_r   <= D_ZERO;
      cy_r        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (cmd_valid) begin
            op_r        <= cmd_op;
            cmd_ready_r <= 1'b0;
            case (cmd_op)
              OP_PUSH: begin
                if (full_r) begin
                  state_r     <= S_RSP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= ERR_OVERFLOW;
                  rsp_data_r  <= D_ZERO;
                  rsp_cy_r    <= 1'b0;
                end else begin
                  wr_addr_r <= push_addr_s;
                  wr_data_r <= cmd_din;
                  state_r   <= S_WR;
                end
              end
              OP_POP, OP_TOP: begin
                if (count_r < C_ONE) begin
                  state_r     <= S_RSP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= ERR_UNDERFLOW;
                  rsp_data_r  <= D_ZERO;
                  rsp_cy_r    <= 1'b0;
                end else begin
                  state_r <= S_RD_A;
                end
              end
              OP_ADD, OP_SUB: begin
                if (count_r < C_TWO) begin
                  state_r     <= S_RSP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= ERR_UNDERFLOW;
                  rsp_data_r  <= D_ZERO;
                  rsp_cy_r    <= 1'b0;
                end else begin
                  state_r <= S_RD_A;
                end
              end
              OP_CLEAR: begin
                state_r     <= S_RSP;
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= ERR_OK;
                rsp_data_r  <= D_ZERO;
                rsp_cy_r    <= 1'b0;
                count_r     <= C_ZERO;
                empty_r     <= 1'b1;
                full_r      <= 1'b0;
                dar_r       <= A_ZERO;
              end
              OP_PEEK_INC: begin
                dar_r   <= dar_inc_s;
                state_r <= S_RD_A;
              end
              OP_PEEK_DEC: begin
                dar_r   <= dar_dec_s;
                state_r <= S_RD_A;
              end
              default: begin
                state_r     <= S_IDLE;
                cmd_ready_r <= 1'b1;
              end
            endcase
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_RD_A: begin
          case (op_r)
            OP_ADD, OP_SUB: begin
              a_r     <= rd_data_r;
              state_r <= S_RD_B;
            end
            OP_POP: begin
              // New top after a pop is one address above the old one; with
              // a single entry this wraps to 0, which is the empty-stack dar.
              state_r     <= S_RSP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= ERR_OK;
              rsp_data_r  <= rd_data_r;
              rsp_cy_r    <= 1'b0;
              count_r     <= count_r - C_ONE;
              empty_r     <= (count_r == C_ONE);
              full_r      <= 1'b0;
              dar_r       <= top_addr_s + A_ONE;
            end
            OP_TOP: begin
              state_r     <= S_RSP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= ERR_OK;
              rsp_data_r  <= rd_data_r;
              rsp_cy_r    <= 1'b0;
              dar_r       <= top_addr_s;
            end
            default: begin
              // PEEK_INC / PEEK_DEC: dar already moved on accept.
              state_r     <= S_RSP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= ERR_OK;
              rsp_data_r  <= rd_data_r;
              rsp_cy_r    <= 1'b0;
            end
          endcase
        end

        S_RD_B: begin
          wr_addr_r <= top_addr_s + A_ONE;
          if (op_r == OP_SUB) begin
            wr_data_r <= diff_s[DW-1:0];
            cy_r      <= diff_s[DW];
          end else begin
            wr_data_r <= sum_s[DW-1:0];
            cy_r      <= sum_s[DW];
          end
          state_r <= S_WR;
        end

        S_WR: begin
          state_r     <= S_RSP;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= ERR_OK;
          rsp_data_r  <= wr_data_r;
          dar_r       <= wr_addr_r;
          if (op_r == OP_PUSH) begin
            rsp_cy_r <= 1'b0;
            count_r  <= count_r + C_ONE;
            empty_r  <= 1'b0;
            full_r   <= (count_r == (C_DEPTH - C_ONE));
          end else begin
            rsp_cy_r <= cy_r;
            count_r  <= count_r - C_ONE;
            empty_r  <= 1'b0;
            full_r   <= 1'b0;
          end
        end

        S_RSP: begin
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end

        default: begin
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_cy    = rsp_cy_r;
  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign dar       = dar_r;

endmodule

// File: tb/tb_stack_calc_core.sv
// -----------------------------------------------------------------------------
// tb_stack_calc_core
//   Directed, table-driven bench for stack_calc_core built with DW=8, AW=3
//   (DEPTH=8). Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stack_calc_core;

  localparam int DW = 8;
  localparam int AW = 3;

  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         TOP  = 3'd4, CLR = 3'd5, PINC = 3'd6, PDEC = 3'd7;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_din;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_err;
  logic          rsp_cy;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic [AW-1:0] dar;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_err;
    logic          exp_cy;
    logic [AW:0]   exp_count;
    logic [AW-1:0] exp_dar;
    int            exp_lat;
  } vec_t;

  vec_t vecs[$];

  logic [DW-1:0] got_data;
  logic [1:0]    got_err;
  logic          got_cy;
  int            got_lat;

  stack_calc_core #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_din   (cmd_din),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_cy    (rsp_cy),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .dar       (dar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [7:0] din, input logic [7:0] d,
                         input logic [1:0] e, input logic cy, input int cnt, input int dr,
                         input int lat);
    vec_t v;
    v.op = op; v.din = din; v.exp_data = d; v.exp_err = e; v.exp_cy = cy;
    v.exp_count = cnt[AW:0]; v.exp_dar = dr[AW-1:0]; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one command starting at a falling edge; returns the response fields and
  // the latency counted in rising edges from the accept edge to the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] din);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_din = din;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    got_lat = 1;
    while (!rsp_valid && got_lat < 20) begin
      @(negedge clk);
      got_lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    got_data = rsp_data; got_err = rsp_err; got_cy = rsp_cy;
  endtask

  task automatic check_pulse_end();
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_din = 8'h00;

    // op, din, data, err, cy, count, dar, latency
    add_vec(PUSH, 8'h12, 8'h12, 2'b00, 1'b0, 1, 7, 2);
    add_vec(PUSH, 8'h34, 8'h34, 2'b00, 1'b0, 2, 6, 2);
    add_vec(TOP,  8'h00, 8'h34, 2'b00, 1'b0, 2, 6, 2);
    add_vec(POP,  8'h00, 8'h34, 2'b00, 1'b0, 1, 7, 2);
    add_vec(POP,  8'h00, 8'h12, 2'b00, 1'b0, 0, 0, 2);
    add_vec(POP,  8'h00, 8'h00, 2'b01, 1'b0, 0, 0, 1);
    add_vec(ADD,  8'h00, 8'h00, 2'b01, 1'b0, 0, 0, 1);
    add_vec(PUSH, 8'hF0, 8'hF0, 2'b00, 1'b0, 1, 7, 2);
    add_vec(PUSH, 8'h20, 8'h20, 2'b00, 1'b0, 2, 6, 2);
    add_vec(ADD,  8'h00, 8'h10, 2'b00, 1'b1, 1, 7, 4);
    add_vec(TOP,  8'h00, 8'h10, 2'b00, 1'b0, 1, 7, 2);
    add_vec(CLR,  8'h00, 8'h00, 2'b00, 1'b0, 0, 0, 1);
    add_vec(PUSH, 8'h05, 8'h05, 2'b00, 1'b0, 1, 7, 2);
    add_vec(PUSH, 8'h07, 8'h07, 2'b00, 1'b0, 2, 6, 2);
    add_vec(SUB,  8'h00, 8'hFE, 2'b00, 1'b1, 1, 7, 4);
    add_vec(ADD,  8'h00, 8'h00, 2'b01, 1'b0, 1, 7, 1);
    add_vec(PDEC, 8'h00, 8'h07, 2'b00, 1'b0, 1, 6, 2);
    add_vec(PINC, 8'h00, 8'hFE, 2'b00, 1'b0, 1, 7, 2);
    add_vec(PUSH, 8'h03, 8'h03, 2'b00, 1'b0, 2, 6, 2);
    add_vec(SUB,  8'h00, 8'hFB, 2'b00, 1'b0, 1, 7, 4);
    add_vec(PUSH, 8'hC0, 8'hC0, 2'b00, 1'b0, 2, 6, 2);
    add_vec(PUSH, 8'h40, 8'h40, 2'b00, 1'b0, 3, 5, 2);
    add_vec(ADD,  8'h00, 8'h00, 2'b00, 1'b1, 2, 6, 4);
    add_vec(TOP,  8'h00, 8'h00, 2'b00, 1'b0, 2, 6, 2);
    add_vec(CLR,  8'h00, 8'h00, 2'b00, 1'b0, 0, 0, 1);

    repeat (3) @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_dar", 32'(dar), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_cy", 32'(rsp_cy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 32'd1);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].din);
      chk($sformatf("v%0d_data", i), 32'(got_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_cy", i), 32'(got_cy), 32'(vecs[i].exp_cy));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_count == 0));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_count == 8));
      chk($sformatf("v%0d_dar", i), 32'(dar), 32'(vecs[i].exp_dar));
      chk($sformatf("v%0d_lat", i), 32'(got_lat), 32'(vecs[i].exp_lat));
      check_pulse_end();
    end

    // Fill the 8-deep stack with 0x80..0x87, then overflow with 0xEE.
    for (int k = 0; k < 8; k++) begin
      issue(PUSH, 8'h80 + 8'(k));
      chk($sformatf("fill%0d_data", k), 32'(got_data), 32'h80 + 32'(k));
      chk($sformatf("fill%0d_count", k), 32'(count), 32'(k + 1));
      check_pulse_end();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_dar", 32'(dar), 32'd0);
    issue(PUSH, 8'hEE);
    chk("ovf_err", 32'(got_err), 32'd2);
    chk("ovf_data", 32'(got_data), 32'd0);
    chk("ovf_lat", 32'(got_lat), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_dar", 32'(dar), 32'd0);
    check_pulse_end();

    // dar=0, PEEK_DEC wraps to DEPTH-1 and returns the (untouched) bottom entry.
    issue(PDEC, 8'h00);
    chk("peek_wrap_dar", 32'(dar), 32'd7);
    chk("peek_wrap_data", 32'(got_data), 32'h80);
    chk("peek_wrap_lat", 32'(got_lat), 32'd2);
    issue(PINC, 8'h00);
    chk("peek_inc_wrap_dar", 32'(dar), 32'd0);
    chk("peek_inc_wrap_data", 32'(got_data), 32'h87);
    issue(POP, 8'h00);
    chk("pop_after_full_data", 32'(got_data), 32'h87);
    chk("pop_after_full_count", 32'(count), 32'd7);
    chk("pop_after_full_dar", 32'(dar), 32'd1);

    // Reset while ADD sits in WR: top=0x86 @1, next=0x85 @2; no write may land.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_din = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midadd_no_rsp_yet", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midadd_rst_count", 32'(count), 32'd0);
    chk("midadd_rst_dar", 32'(dar), 32'd0);
    chk("midadd_rst_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midadd_ready", 32'(cmd_ready), 32'd1);
    issue(PINC, 8'h00);
    chk("midadd_peek1", 32'(got_data), 32'h86);
    issue(PINC, 8'h00);
    chk("midadd_peek2_nowrite", 32'(got_data), 32'h85);
    chk("midadd_peek2_dar", 32'(dar), 32'd2);
    chk("midadd_empty", 32'(empty), 32'd1);

    // Requests while busy must be ignored: valid held through a PUSH runs it once.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_din = 8'h55;
    @(posedge clk);
    @(negedge clk);
    chk("busy_ready_low", 32'(cmd_ready), 32'd0);
    cmd_op = POP;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_ignored_count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
